seg_scan_ctrl: RTL
==================

Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a multi-digit common-anode 7-segment display.
- Holds a display word written by the host (CPU/debug logic) and lights one digit at a time through a single shared hex-to-7-segment decoder.
- Inserts blanking gaps between digits to prevent ghosting.
- Sits between the MCPC debug/status registers and the board display pins.

Parameters:
DIGITS, 4, number of digits scanned (>=2)
SHOW_CYCLES, 50000, clock cycles each digit is lit (>=1)
BLANK_CYCLES, 500, clock cycles all digits are dark between digits (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
en  in  1  scan enable; 0 = display dark
wr_en  in  1  one-cycle write strobe for wr_data/wr_dp
wr_data  in  4*DIGITS  hex nibbles; nibble i drives digit i (digit 0 = rightmost, bits 3:0)
wr_dp  in  DIGITS  decimal-point mask, bit i for digit i
lz_blank  in  1  1 = suppress leading zeros
seg  out  7  segment drive, active-high, bit0=a … bit6=g
dp  out  1  decimal point, active-high
an_n  out  DIGITS  digit anodes, active-low, at most one low
frame_done  out  1  one-cycle pulse at end of each full scan frame

Behaviour:
- Reset (rst=1 on a clock edge): state=IDLE, idx=0, cnt=0, pending and shadow registers cleared to 0. Outputs: seg=0, dp=0, an_n=all 1, frame_done=0. Reset mid-scan aborts immediately.
- Registers:
  - pending (data+dp): written on every wr_en, regardless of state.
  - shadow: what is displayed. Copied from pending only at frame boundaries or on leaving IDLE.
  - If wr_en coincides with a copy, the new wr_data/wr_dp go into shadow directly, so no tearing within a frame.
- All outputs are flops driven from next-state values, so they change on the same edge as the state they describe. There is no extra lag.
- States:
  - IDLE: outputs dark. If en=1, go to SHOW with idx=0, cnt=0, and load shadow.
  - SHOW: an_n[idx]=0, others 1.
    - seg = decode(shadow nibble idx); dp = shadow_dp[idx].
    - cnt counts 0..SHOW_CYCLES-1. At SHOW_CYCLES-1, go to BLANK with cnt=0.
  - BLANK: an_n all 1, seg=0, dp=0. cnt counts 0..BLANK_CYCLES-1. At the last count:
    - if idx==DIGITS-1: idx=0, shadow<=pending, frame_done=1 for exactly that cycle;
    - else idx=idx+1;
    - then go to SHOW with cnt=0.
- en=0 in any state: next cycle state=IDLE, idx=0, cnt=0, outputs dark, frame_done=0. Pending is kept.
- Timing:
  - Each digit is lit for exactly SHOW_CYCLES consecutive cycles.
  - Frame period = DIGITS*(SHOW_CYCLES+BLANK_CYCLES) cycles.
  - First digit is lit on the edge after en is first sampled high.
- Leading-zero suppression (lz_blank=1):
  - Digit i, i>0, is blanked (seg=0) when it and all higher nibbles of shadow are 0. Its anode is still driven, and dp is still shown.
  - Digit 0 is never blanked.
  - lz_blank is sampled live, not shadowed.
- Counter width = clog2(max(SHOW_CYCLES,BLANK_CYCLES)). idx width = clog2(DIGITS). Both wrap only as described above; no free-running overflow.

Decomposition:
- Package seg_pkg holds:
  - state enum (IDLE, SHOW, BLANK);
  - SEG_OFF=7'b0000000;
  - NIBBLE_W=4;
  - a clog2 helper function.
- One sub-module: the existing hexto7segment decoder, instantiated once. Its input is the shadow nibble selected by idx (or next idx).
- Leading-zero mask and nibble mux stay inline.

Test Plan:
- Use DIGITS=4, SHOW_CYCLES=4, BLANK_CYCLES=1 throughout.
- Reset then en=1, wr_data=16'h1A3F: scan order is
  - an_n 1110 with seg=7'b1110001 (F) for 4 cycles, then 1 dark cycle;
  - then 1101/7'b1001111 (3), 1011/7'b1110111 (A), 0111/7'b0000110 (1);
  - frame_done pulses once every 20 cycles.
- Write 16'h2222 mid-frame while digit 1 is lit: remaining digits of the current frame still show 1A3F values. The next frame shows 2 (7'b1011011) on all digits. frame_done aligns with the switch.
- wr_en on the exact frame-boundary cycle with 16'h0005, lz_blank=1: the next frame shows digit 0 = 7'b1101101 and digits 1-3 with anode low but seg=0.
- wr_dp=4'b0100: dp=1 only while an_n=1011, and dp=0 in all blank cycles.
- Drop en mid-SHOW for 3 cycles, then re-raise: outputs are dark the cycle after en falls. Scan restarts at digit 0 with a full 4-cycle SHOW. Assert rst mid-BLANK: all outputs at reset values next edge, and the display shows 0000 after re-enable.

Source files
------------

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the 7-segment scan controller.
// Scan FSM encoding, segment constants and a width helper.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } scan_state_e;

    localparam logic [6:0] SEG_OFF  = 7'b0000000;
    localparam int         NIBBLE_W = 4;

    // Ceiling log2, never below 1 so a one-value counter still has a bit.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_hex7seg.sv
// Hex nibble to active-high 7-segment pattern (bit0 = a ... bit6 = g).
module hexto7segment
    import seg_pkg::*;
(
    input  logic [NIBBLE_W-1:0] nibble,
    output logic [6:0]          seg
);

    always_comb begin
        seg = SEG_OFF;
        case (nibble)
            4'h0: seg = 7'b0111111;
            4'h1: seg = 7'b0000110;
            4'h2: seg = 7'b1011011;
            4'h3: seg = 7'b1001111;
            4'h4: seg = 7'b1100110;
            4'h5: seg = 7'b1101101;
            4'h6: seg = 7'b1111101;
            4'h7: seg = 7'b0000111;
            4'h8: seg = 7'b1111111;
            4'h9: seg = 7'b1101111;
            4'hA: seg = 7'b1110111;
            4'hB: seg = 7'b1111100;
            4'hC: seg = 7'b0111001;
            4'hD: seg = 7'b1011110;
            4'hE: seg = 7'b1111001;
            4'hF: seg = 7'b1110001;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// Outputs are registered from next-state values so they align with the state they describe.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int SHOW_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         wr_en,
    input  logic [NIBBLE_W*DIGITS-1:0]   wr_data,
    input  logic [DIGITS-1:0]            wr_dp,
    input  logic                         lz_blank,
    output logic [6:0]                   seg,
    output logic                         dp,
    output logic [DIGITS-1:0]            an_n,
    output logic                         frame_done
);

    localparam int CNT_MAX = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = clog2(CNT_MAX);
    localparam int IDX_W   = clog2(DIGITS);
    localparam int DATA_W  = NIBBLE_W * DIGITS;

    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

    scan_state_e       state, state_n;
    logic [IDX_W-1:0]  idx, idx_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [DATA_W-1:0] pend_data, pend_data_n, shad_data, shad_data_n;
    logic [DIGITS-1:0] pend_dp, pend_dp_n, shad_dp, shad_dp_n;
    logic              load, frame_next;

    logic [NIBBLE_W-1:0] nib_sel;
    logic [6:0]          dec_seg;
    logic [DIGITS-1:0]   upper_zero;
    logic                dp_sel, lz_hide, zero_run;
    logic [6:0]          seg_next;
    logic                dp_next;
    logic [DIGITS-1:0]   an_next;

    always_comb begin
        state_n    = state;
        idx_n      = idx;
        cnt_n      = cnt;
        load       = 1'b0;
        frame_next = 1'b0;
        pend_data_n = wr_en ? wr_data : pend_data;
        pend_dp_n   = wr_en ? wr_dp   : pend_dp;

        if (!en) begin
            state_n = IDLE;
            idx_n   = '0;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_n = SHOW;
                    idx_n   = '0;
                    cnt_n   = '0;
                    load    = 1'b1;
                end
                SHOW: begin
                    if (cnt == SHOW_LAST) begin
                        state_n = BLANK;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state_n = SHOW;
                        cnt_n   = '0;
                        if (idx == IDX_LAST) begin
                            idx_n      = '0;
                            load       = 1'b1;
                            frame_next = 1'b1;
                        end else begin
                            idx_n = idx + IDX_W'(1);
                        end
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                    idx_n   = '0;
                    cnt_n   = '0;
                end
            endcase
        end

        // Loading from the next pending value lets a coincident write land in the new frame.
        shad_data_n = load ? pend_data_n : shad_data;
        shad_dp_n   = load ? pend_dp_n   : shad_dp;
    end

    // Leading-zero detection: upper_zero[i] means nibble i and all above it are zero.
    always_comb begin
        upper_zero = '0;
        zero_run   = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run      = zero_run & (shad_data_n[i*NIBBLE_W +: NIBBLE_W] == '0);
            upper_zero[i] = zero_run;
        end
    end

    always_comb begin
        nib_sel = '0;
        dp_sel  = 1'b0;
        lz_hide = 1'b0;
        an_next = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_n == IDX_W'(i)) begin
                nib_sel = shad_data_n[i*NIBBLE_W +: NIBBLE_W];
                dp_sel  = shad_dp_n[i];
                lz_hide = lz_blank && (i != 0) && upper_zero[i];
                if (state_n == SHOW) an_next[i] = 1'b0;
            end
        end
    end

    hexto7segment u_dec (
        .nibble (nib_sel),
        .seg    (dec_seg)
    );

    always_comb begin
        seg_next = SEG_OFF;
        dp_next  = 1'b0;
        if (state_n == SHOW) begin
            seg_next = lz_hide ? SEG_OFF : dec_seg;
            dp_next  = dp_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            pend_data  <= '0;
            pend_dp    <= '0;
            shad_data  <= '0;
            shad_dp    <= '0;
            seg        <= SEG_OFF;
            dp         <= 1'b0;
            an_n       <= '1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            cnt        <= cnt_n;
            pend_data  <= pend_data_n;
            pend_dp    <= pend_dp_n;
            shad_data  <= shad_data_n;
            shad_dp    <= shad_dp_n;
            seg        <= seg_next;
            dp         <= dp_next;
            an_n       <= an_next;
            frame_done <= frame_next;
        end
    end

endmodule
